// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM port arbiter.
// Optional overrun flag: VRAM_ARB_OVERRUN_EN.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    V1,
    V2,
    CPU
  } arb_state_t;

  localparam int AW = 19;
  localparam int DW = 16;

endpackage

// File: rtl/vram_arbiter.sv
// Video/CPU arbiter for one single-port 16-bit VRAM.
// Define VRAM_ARB_OVERRUN_EN to add the sticky vid_overrun flag.
module vram_arbiter
  import vram_arb_pkg::*;
#(
  parameter int RAM_LAT = 2,
  parameter int AW      = vram_arb_pkg::AW
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr1,
  input  logic [AW-1:0] vid_addr2,
  output logic [DW-1:0] vid_dout1,
  output logic [DW-1:0] vid_dout2,
  output logic          vid_valid,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW:0]   cpu_addr,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  output logic          cpu_ack,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  output logic [1:0]    ram_be,
  input  logic [DW-1:0] ram_dout
`ifdef VRAM_ARB_OVERRUN_EN
  ,
  output logic          vid_overrun
`endif
);

  localparam logic [1:0] CNT_LD = 2'(RAM_LAT - 1);

  arb_state_t    state_q, state_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] va1_q, va1_d;
  logic [AW-1:0] va2_q, va2_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          iss_q, iss_d;
  logic [DW-1:0] w1_q, w1_d;
  logic          ca0_q, ca0_d;
  logic          cwe_q, cwe_d;
  logic [DW-1:0] vd1_q, vd1_d;
  logic [DW-1:0] vd2_q, vd2_d;
  logic          vval_q, vval_d;
  logic [7:0]    cdo_q, cdo_d;
  logic          ack_q, ack_d;
  logic [AW-1:0] radr_q, radr_d;
  logic [DW-1:0] rdin_q, rdin_d;
  logic          rwe_q, rwe_d;
  logic [1:0]    rbe_q, rbe_d;
  logic          done;
  logic          in_vid;

  assign in_vid = (state_q == V1) || (state_q == V2);
  assign done   = (state_q != IDLE) && !iss_q &&
                  (cnt_q == 2'd0);

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    va1_d   = va1_q;
    va2_d   = va2_q;
    cnt_d   = cnt_q;
    iss_d   = 1'b0;
    w1_d    = w1_q;
    ca0_d   = ca0_q;
    cwe_d   = cwe_q;
    vd1_d   = vd1_q;
    vd2_d   = vd2_q;
    vval_d  = 1'b0;
    cdo_d   = cdo_q;
    ack_d   = 1'b0;
    radr_d  = radr_q;
    rdin_d  = rdin_q;
    rwe_d   = 1'b0;
    rbe_d   = rbe_q;

    // A request during V1/V2 retargets the pair in flight.
    if (vid_req) begin
      va1_d = vid_addr1;
      va2_d = vid_addr2;
      if (!in_vid) pend_d = 1'b1;
    end

    if (state_q != IDLE) begin
      if (iss_q)
        cnt_d = CNT_LD;
      else if (cnt_q != 2'd0)
        cnt_d = cnt_q - 2'd1;
    end

    unique case (state_q)
      IDLE: begin
        if (pend_d) begin
          state_d = V1;
          pend_d  = 1'b0;
          iss_d   = 1'b1;
          radr_d  = va1_d;
          rbe_d   = 2'b11;
        end else if (cpu_req && !ack_q) begin
          state_d = CPU;
          iss_d   = 1'b1;
          ca0_d   = cpu_addr[0];
          cwe_d   = cpu_we;
          radr_d  = cpu_addr[AW:1];
          rdin_d  = {cpu_din, cpu_din};
          rwe_d   = cpu_we;
          rbe_d   = !cpu_we     ? 2'b11 :
                    cpu_addr[0] ? 2'b10 : 2'b01;
        end
      end
      V1: begin
        if (done) begin
          state_d = V2;
          iss_d   = 1'b1;
          w1_d    = ram_dout;
          radr_d  = va2_d;
        end
      end
      V2: begin
        if (done) begin
          state_d = IDLE;
          vd1_d   = w1_q;
          vd2_d   = ram_dout;
          vval_d  = 1'b1;
        end
      end
      CPU: begin
        if (done) begin
          state_d = IDLE;
          ack_d   = 1'b1;
          if (!cwe_q)
            cdo_d = ca0_q ? ram_dout[15:8]
                          : ram_dout[7:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
      va1_q   <= '0;
      va2_q   <= '0;
      cnt_q   <= '0;
      iss_q   <= 1'b0;
      w1_q    <= '0;
      ca0_q   <= 1'b0;
      cwe_q   <= 1'b0;
      vd1_q   <= '0;
      vd2_q   <= '0;
      vval_q  <= 1'b0;
      cdo_q   <= '0;
      ack_q   <= 1'b0;
      radr_q  <= '0;
      rdin_q  <= '0;
      rwe_q   <= 1'b0;
      rbe_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      va1_q   <= va1_d;
      va2_q   <= va2_d;
      cnt_q   <= cnt_d;
      iss_q   <= iss_d;
      w1_q    <= w1_d;
      ca0_q   <= ca0_d;
      cwe_q   <= cwe_d;
      vd1_q   <= vd1_d;
      vd2_q   <= vd2_d;
      vval_q  <= vval_d;
      cdo_q   <= cdo_d;
      ack_q   <= ack_d;
      radr_q  <= radr_d;
      rdin_q  <= rdin_d;
      rwe_q   <= rwe_d;
      rbe_q   <= rbe_d;
    end
  end

`ifdef VRAM_ARB_OVERRUN_EN
  logic ovr_q;

  always_ff @(posedge clk_sys) begin
    if (reset)
      ovr_q <= 1'b0;
    else if (vid_req && (pend_q || in_vid))
      ovr_q <= 1'b1;
  end

  assign vid_overrun = ovr_q;
`endif

  assign vid_dout1 = vd1_q;
  assign vid_dout2 = vd2_q;
  assign vid_valid = vval_q;
  assign cpu_dout  = cdo_q;
  assign cpu_ack   = ack_q;
  assign ram_addr  = radr_q;
  assign ram_din   = rdin_q;
  // Strobe must not outlive a reset seen mid-write.
  assign ram_we    = rwe_q && !reset;
  assign ram_be    = rbe_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a RAM_LAT=2 RAM model.
// Define VRAM_ARB_OVERRUN_EN to also exercise vid_overrun.
module tb_vram_arbiter;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        vid_req;
  logic [18:0] vid_addr1;
  logic [18:0] vid_addr2;
  logic [15:0] vid_dout1;
  logic [15:0] vid_dout2;
  logic        vid_valid;
  logic        cpu_req;
  logic        cpu_we;
  logic [19:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic [7:0]  cpu_dout;
  logic        cpu_ack;
  logic [18:0] ram_addr;
  logic [15:0] ram_din;
  logic        ram_we;
  logic [1:0]  ram_be;
  logic [15:0] ram_dout;
`ifdef VRAM_ARB_OVERRUN_EN
  logic        vid_overrun;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_sys = ~clk_sys;

  vram_arbiter #(.RAM_LAT(2), .AW(19)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .vid_req   (vid_req),
    .vid_addr1 (vid_addr1),
    .vid_addr2 (vid_addr2),
    .vid_dout1 (vid_dout1),
    .vid_dout2 (vid_dout2),
    .vid_valid (vid_valid),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_ack   (cpu_ack),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_be    (ram_be),
    .ram_dout  (ram_dout)
`ifdef VRAM_ARB_OVERRUN_EN
    ,
    .vid_overrun (vid_overrun)
`endif
  );

  // RAM: word 0x40 holds 0x1234, others return addr[15:0].
  logic [15:0] p1, p2;
  always @(posedge clk_sys) begin
    p1 <= (ram_addr == 19'h00040) ? 16'h1234
                                  : ram_addr[15:0];
    p2 <= p1;
  end
  assign ram_dout = p2;

  task automatic step;
    @(negedge clk_sys);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    vid_req = 1'b0;
    vid_addr1 = '0;
    vid_addr2 = '0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_din = '0;
    step;
    step;
    checks++;
    if ({ram_addr, ram_din, ram_we, ram_be} !== '0)
      $display("FAIL reset_ram got=%h/%h/%b/%b exp=0",
               ram_addr, ram_din, ram_we, ram_be);
    checks++;
    if ({vid_dout1, vid_dout2, vid_valid} !== '0)
      $display("FAIL reset_vid got=%h/%h/%b exp=0",
               vid_dout1, vid_dout2, vid_valid);
    checks++;
    if ({cpu_dout, cpu_ack} !== '0)
      $display("FAIL reset_cpu got=%h/%b exp=0",
               cpu_dout, cpu_ack);
    if ({ram_addr, ram_din, ram_we, ram_be} !== '0 ||
        {vid_dout1, vid_dout2, vid_valid} !== '0 ||
        {cpu_dout, cpu_ack} !== '0)
      errors++;
    reset = 1'b0;
  endtask

  task automatic test_video;
    logic [18:0] ea;
    vid_addr1 = 19'h00010;
    vid_addr2 = 19'h00011;
    vid_req = 1'b1;
    step;
    vid_req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (k <= 6) begin
        ea = (k <= 3) ? 19'h00010 : 19'h00011;
        checks++;
        if (ram_addr !== ea) begin
          errors++;
          $display("FAIL vid_addr k=%0d got=%h exp=%h",
                   k, ram_addr, ea);
        end
      end
      checks++;
      if (vid_valid !== 1'(k == 7)) begin
        errors++;
        $display("FAIL vid_valid k=%0d got=%b exp=%b",
                 k, vid_valid, (k == 7));
      end
      if (k == 7) begin
        checks++;
        if (vid_dout1 !== 16'h0010 ||
            vid_dout2 !== 16'h0011) begin
          errors++;
          $display("FAIL vid_data got=%h/%h exp=0010/0011",
                   vid_dout1, vid_dout2);
        end
      end
      step;
    end
  endtask

  task automatic test_cpu_write;
    cpu_addr = 20'h00021;
    cpu_din = 8'hA5;
    cpu_we = 1'b1;
    cpu_req = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step;
      if (k == 1) begin
        checks++;
        if (ram_addr !== 19'h00010 || ram_be !== 2'b10 ||
            ram_din !== 16'hA5A5 || ram_we !== 1'b1) begin
          errors++;
          $display("FAIL wr_issue got=%h/%b/%h/%b exp=10/10/a5a5/1",
                   ram_addr, ram_be, ram_din, ram_we);
        end
      end else if (k <= 3) begin
        checks++;
        if (ram_we !== 1'b0 || ram_addr !== 19'h00010) begin
          errors++;
          $display("FAIL wr_hold k=%0d got=%b/%h exp=0/10",
                   k, ram_we, ram_addr);
        end
      end
      checks++;
      if (cpu_ack !== 1'(k == 4)) begin
        errors++;
        $display("FAIL wr_ack k=%0d got=%b exp=%b",
                 k, cpu_ack, (k == 4));
      end
      if (cpu_ack) cpu_req = 1'b0;
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_cpu_read;
    logic [19:0] ta [2];
    logic [7:0]  te [2];
    int ak;
    ta[0] = 20'h00081; te[0] = 8'h12;
    ta[1] = 20'h00080; te[1] = 8'h34;
    for (int v = 0; v < 2; v++) begin
      cpu_addr = ta[v];
      cpu_we = 1'b0;
      cpu_din = 8'hFF;
      cpu_req = 1'b1;
      ak = -1;
      for (int k = 1; k <= 8; k++) begin
        step;
        if (k == 1) begin
          checks++;
          if (ram_addr !== 19'h00040 || ram_be !== 2'b11 ||
              ram_we !== 1'b0) begin
            errors++;
            $display("FAIL rd_issue v=%0d got=%h/%b/%b exp=40/11/0",
                     v, ram_addr, ram_be, ram_we);
          end
        end
        if (cpu_ack && ak < 0) begin
          ak = k;
          cpu_req = 1'b0;
          checks++;
          if (cpu_dout !== te[v]) begin
            errors++;
            $display("FAIL rd_data v=%0d got=%h exp=%h",
                     v, cpu_dout, te[v]);
          end
        end
      end
      checks++;
      if (ak != 4) begin
        errors++;
        $display("FAIL rd_lat v=%0d got=%0d exp=4", v, ak);
      end
      cpu_req = 1'b0;
    end
  endtask

  task automatic test_simultaneous;
    int vk, ak, nv;
    vk = -1; ak = -1; nv = 0;
    vid_addr1 = 19'h00020;
    vid_addr2 = 19'h00021;
    vid_req = 1'b1;
    cpu_addr = 20'h00081;
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    step;
    vid_req = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      if (k == 1) begin
        checks++;
        if (ram_addr !== 19'h00020) begin
          errors++;
          $display("FAIL sim_first got=%h exp=20", ram_addr);
        end
      end
      if (vid_valid) begin
        nv++;
        if (vk < 0) vk = k;
      end
      if (cpu_ack && ak < 0) begin
        ak = k;
        cpu_req = 1'b0;
      end
      step;
    end
    checks++;
    if (vk != 7 || nv != 1 || vid_dout2 !== 16'h0021) begin
      errors++;
      $display("FAIL sim_vid got=%0d/%0d/%h exp=7/1/0021",
               vk, nv, vid_dout2);
    end
    checks++;
    if (ak != 11 || cpu_dout !== 8'h12) begin
      errors++;
      $display("FAIL sim_cpu got=%0d/%h exp=11/12", ak, cpu_dout);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_cpu_then_vid;
    int a1, a2, vk;
    a1 = -1; a2 = -1; vk = -1;
    cpu_addr = 20'h00080;
    cpu_we = 1'b0;
    cpu_req = 1'b1;
    step;
    vid_addr1 = 19'h00030;
    vid_addr2 = 19'h00031;
    vid_req = 1'b1;
    step;
    vid_req = 1'b0;
    for (int k = 2; k <= 18; k++) begin
      if (k == 5) begin
        checks++;
        if (ram_addr !== 19'h00030) begin
          errors++;
          $display("FAIL pre_v1 got=%h exp=30", ram_addr);
        end
      end
      if (vid_valid && vk < 0) vk = k;
      if (cpu_ack) begin
        if (a1 < 0) a1 = k;
        else if (a2 < 0) begin
          a2 = k;
          cpu_req = 1'b0;
        end
      end
      step;
    end
    checks++;
    if (a1 != 4) begin
      errors++;
      $display("FAIL pre_ack1 got=%0d exp=4", a1);
    end
    checks++;
    if (vk != 11 || vid_dout1 !== 16'h0030 ||
        vid_dout2 !== 16'h0031) begin
      errors++;
      $display("FAIL pre_vid got=%0d/%h/%h exp=11/0030/0031",
               vk, vid_dout1, vid_dout2);
    end
    checks++;
    if (a2 != 15 || cpu_dout !== 8'h34) begin
      errors++;
      $display("FAIL pre_ack2 got=%0d/%h exp=15/34", a2, cpu_dout);
    end
    cpu_req = 1'b0;
  endtask

  task automatic test_reset_v2;
    int nv;
    nv = 0;
    vid_addr1 = 19'h00050;
    vid_addr2 = 19'h00051;
    vid_req = 1'b1;
    step;
    vid_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (vid_valid) nv++;
      if (k < 5) step;
    end
    reset = 1'b1;
    step;
    checks++;
    if ({ram_addr, ram_din, ram_we, ram_be, vid_dout1,
         vid_dout2, vid_valid, cpu_dout, cpu_ack} !== '0) begin
      errors++;
      $display("FAIL rst_v2 got=%h/%h/%h/%h/%h exp=0",
               ram_addr, ram_be, vid_dout1, vid_dout2, cpu_dout);
    end
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step;
      if (vid_valid) nv++;
    end
    checks++;
    if (nv != 0) begin
      errors++;
      $display("FAIL rst_v2_valid got=%0d exp=0", nv);
    end
  endtask

  task automatic test_reset_write;
    int na;
    na = 0;
    cpu_addr = 20'h00021;
    cpu_din = 8'h5A;
    cpu_we = 1'b1;
    cpu_req = 1'b1;
    step;
    checks++;
    if (ram_we !== 1'b1) begin
      errors++;
      $display("FAIL rstw_issue got=%b exp=1", ram_we);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (ram_we !== 1'b0) begin
      errors++;
      $display("FAIL rstw_we got=%b exp=0", ram_we);
    end
    cpu_req = 1'b0;
    step;
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (cpu_ack) na++;
      step;
    end
    checks++;
    if (na != 0) begin
      errors++;
      $display("FAIL rstw_ack got=%0d exp=0", na);
    end
  endtask

`ifdef VRAM_ARB_OVERRUN_EN
  task automatic test_overrun;
    int nv;
    nv = 0;
    checks++;
    if (vid_overrun !== 1'b0) begin
      errors++;
      $display("FAIL ovr_init got=%b exp=0", vid_overrun);
    end
    vid_addr1 = 19'h00060;
    vid_addr2 = 19'h00061;
    vid_req = 1'b1;
    step;
    vid_req = 1'b0;
    step;
    vid_addr1 = 19'h00070;
    vid_addr2 = 19'h00071;
    vid_req = 1'b1;
    step;
    vid_req = 1'b0;
    checks++;
    if (vid_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_set got=%b exp=1", vid_overrun);
    end
    for (int k = 0; k < 14; k++) begin
      if (vid_valid) nv++;
      step;
    end
    checks++;
    if (nv != 1 || vid_dout1 !== 16'h0060 ||
        vid_dout2 !== 16'h0071) begin
      errors++;
      $display("FAIL ovr_pair got=%0d/%h/%h exp=1/0060/0071",
               nv, vid_dout1, vid_dout2);
    end
    repeat (1000) step;
    checks++;
    if (vid_overrun !== 1'b1) begin
      errors++;
      $display("FAIL ovr_sticky got=%b exp=1", vid_overrun);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_video();
    test_cpu_write();
    test_cpu_read();
    test_simultaneous();
    test_cpu_then_vid();
    test_reset_v2();
    test_reset_write();
`ifdef VRAM_ARB_OVERRUN_EN
    test_overrun();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
